// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 stream mux (fixed select or round-robin) with a single registered output slot; in_data/in_valid/in_ready per channel, out_data/out_chan/out_valid/out_ready downstream
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int NSEL = 2**SEL_W;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d, rr_ptr_q, rr_ptr_d, rr_gnt, gnt;
  logic out_valid_q, out_valid_d, load_en, rr_vld, gnt_vld, xfer;
  logic [NSEL-1:0] vld_pad;
  assign vld_pad = NSEL'(in_valid);
  assign load_en = !out_valid_q || out_ready;
  always_comb begin : rr_search
    logic [SEL_W:0] idx;
    idx    = '0;
    rr_gnt = '0;
    rr_vld = 1'b0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
      idx = (idx >= (SEL_W+1)'(CHANNELS)) ? idx - (SEL_W+1)'(CHANNELS) : idx;
      if (vld_pad[idx[SEL_W-1:0]]) begin
        rr_gnt = idx[SEL_W-1:0];
        rr_vld = 1'b1;
      end
    end
  end
  assign gnt      = mode ? rr_gnt : sel;
  assign gnt_vld  = mode ? rr_vld : vld_pad[sel];
  assign xfer     = load_en && gnt_vld;
  assign in_ready = (xfer && !rst) ? CHANNELS'(1) << gnt : '0;
  always_comb begin
    out_valid_d = load_en ? gnt_vld : out_valid_q;
    out_data_d  = xfer ? in_data[gnt*WIDTH +: WIDTH] : out_data_q;
    out_chan_d  = xfer ? gnt : out_chan_q;
    rr_ptr_d    = xfer ? gnt : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= SEL_W'(CHANNELS-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width of every channel in bits.
REQ-002 Parameter CHANNELS, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SEL_W, default 2, select/channel-index width; SHALL equal clog2(CHANNELS).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SEL_W  channel index used in fixed mode.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_chan  output  SEL_W  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  output holds a valid word.
REQ-014 out_ready  input  1  downstream accepts out_data when high with out_valid.

Function
REQ-015 The block SHALL contain a single-entry output register (out_data, out_chan, out_valid) and a round-robin pointer rr_ptr (SEL_W bits).
REQ-016 load_en SHALL be asserted when out_valid is 0, or out_valid and out_ready are both 1.
REQ-017 Fixed mode: the granted channel SHALL be sel when sel < CHANNELS and in_valid[sel] is 1; otherwise no grant.
REQ-018 Fixed mode: valid bits of non-selected channels SHALL be ignored; in_ready SHALL stay 0 on them.
REQ-019 Round-robin mode: the granted channel SHALL be the first channel with in_valid high, searching from (rr_ptr+1) mod CHANNELS upward with wrap-around.
REQ-020 in_ready[g] SHALL be high, combinationally, only for the granted channel g and only while load_en is 1.
REQ-021 A transfer on channel g occurs when in_valid[g] and in_ready[g] are both 1.
REQ-022 On a transfer, the next edge SHALL load out_data = channel g data, out_chan = g, out_valid = 1.
REQ-023 When load_en is 1 and no grant exists, the next edge SHALL clear out_valid; out_data and out_chan SHALL hold.
REQ-024 When out_valid is 1 and out_ready is 0, out_data, out_chan and out_valid SHALL hold unchanged, and all in_ready SHALL be 0.
REQ-025 Latency SHALL be one cycle from input transfer to out_valid.
REQ-026 Throughput SHALL be one word per cycle when out_ready is held high.
REQ-027 rr_ptr SHALL update to g on every transfer in either mode, and hold otherwise.
REQ-028 Changes to mode or sel SHALL affect only the grant decision for the current cycle; a word already in the output register SHALL be unaffected.
REQ-029 The block SHALL neither drop nor duplicate a word: each transfer SHALL produce exactly one output handshake.

Reset
REQ-030 With rst high at a rising edge, out_valid SHALL become 0, out_data 0, out_chan 0, and rr_ptr CHANNELS-1, so channel 0 has first priority.
REQ-031 While rst is high, all in_ready bits SHALL be 0.
REQ-032 Reset mid-operation SHALL discard any word held in the output register without an output handshake.

Verification
REQ-033 Fixed select: mode=0, sel=2, in_valid=4'b1111, out_ready=1 -> only in_ready[2]=1; out_chan=2 every cycle, one cycle after each transfer.
REQ-034 Round-robin fairness: mode=1, all in_valid=1, out_ready=1 after reset -> out_chan sequence 0,1,2,3,0,1...
REQ-035 Sparse round-robin: mode=1, in_valid=4'b1010 -> out_chan alternates 1,3,1,3; channels 0 and 2 are never granted.
REQ-036 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_chan are stable and in_ready=0; after out_ready=1, the next word follows with no gap and no loss.
REQ-037 Out-of-range select: CHANNELS=3, SEL_W=2, mode=0, sel=3 -> no in_ready high; out_valid drops to 0 after the current word drains.
REQ-038 Reset mid-stream: rst pulsed for 1 cycle while out_valid=1 -> out_valid=0 next cycle; the next round-robin grant goes to channel 0.
